// File: rtl/dir_ctrl_pkg.sv
// Shared types and default constants for the direction controller.
package dir_ctrl_pkg;

  typedef enum logic [1:0] {
    S_UP    = 2'd0,
    S_DOWN  = 2'd1,
    S_PAUSE = 2'd2
  } dir_state_t;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int TICK_DIV_DEF   = 8;

endpackage

// File: rtl/dir_ctrl_debounce.sv
// One push button: 2-flop synchronizer, stability counter and a one-cycle
// press pulse raised the cycle after the debounced level rises.
module debounce
  import dir_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic       sync1_reg, sync2_reg;
  logic       level_reg, level_d_reg;
  logic       press_reg;
  logic [7:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      press_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      // Counter hitting DEB_CYCLES-1 means this is the DEB_CYCLES-th differing cycle.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DEB_LAST) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end
      level_d_reg <= level_reg;
      press_reg   <= level_reg & ~level_d_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/dir_ctrl.sv
// Up/down direction selector with debounced buttons and a free-running step tick.
// Define DIR_CTRL_PAUSE_EN to make a simultaneous press toggle a paused state.
module dir_ctrl
  import dir_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic count_up,
  output logic tick,
  output logic paused
);

  localparam int            DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       up_press, down_press;

  assign btn_raw = {btn_down, btn_up};

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_raw[gi]),
      .press (press[gi])
    );
  end

  assign up_press   = press[0];
  assign down_press = press[1];

  dir_state_t    state_reg, state_next;
  logic          count_up_reg, count_up_next;
  logic          tick_reg;
  logic [DW-1:0] div_reg, div_next;
`ifdef DIR_CTRL_PAUSE_EN
  logic          saved_reg, saved_next;
`endif

  // The divider is never touched by the FSM, so tick spacing is fixed.
  always_comb begin
    div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
  end

  always_comb begin
    state_next = state_reg;
`ifdef DIR_CTRL_PAUSE_EN
    saved_next = saved_reg;
`endif
    case (state_reg)
      S_UP, S_DOWN: begin
        if (up_press && down_press) begin
`ifdef DIR_CTRL_PAUSE_EN
          state_next = S_PAUSE;
          saved_next = (state_reg == S_UP);
`else
          state_next = state_reg;
`endif
        end else if (up_press) begin
          state_next = S_UP;
        end else if (down_press) begin
          state_next = S_DOWN;
        end
      end
`ifdef DIR_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (up_press && down_press) begin
          state_next = saved_reg ? S_UP : S_DOWN;
        end else if (up_press) begin
          state_next = S_UP;
        end else if (down_press) begin
          state_next = S_DOWN;
        end
      end
`endif
      default: state_next = S_UP;
    endcase
    count_up_next = (state_next == S_PAUSE) ? count_up_reg : (state_next == S_UP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_UP;
      count_up_reg <= 1'b1;
      tick_reg     <= 1'b0;
      div_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      count_up_reg <= count_up_next;
      // Gate on the next state so tick is never seen alongside paused.
      tick_reg     <= (div_reg == DIV_LAST) && (state_next != S_PAUSE);
      div_reg      <= div_next;
    end
  end

`ifdef DIR_CTRL_PAUSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      saved_reg <= 1'b1;
    end else begin
      saved_reg <= saved_next;
    end
  end

  assign paused = (state_reg == S_PAUSE);
`else
  assign paused = 1'b0;
`endif

  assign count_up = count_up_reg;
  assign tick     = tick_reg;

endmodule

// File: tb/tb_dir_ctrl.sv
// Scoreboard bench for dir_ctrl (DEB_CYCLES=4, TICK_DIV=8): stimulus queues
// expected tick cycles and direction changes, a monitor pops them as they occur.
module tb_dir_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic count_up, tick, paused;

  always #5 clk = ~clk;

  dir_ctrl #(.DEB_CYCLES(4), .TICK_DIV(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .count_up (count_up),
    .tick     (tick),
    .paused   (paused)
  );

  // Cycles since the last reset release (posedges counted).
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int   at;
    logic val;
  } dir_exp_t;

  dir_exp_t dir_q[$];
  int       tick_q[$];
  int       n_checks = 0;
  int       n_fail = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic plan_ticks(input int a, input int b);
    for (int k = a; k <= b; k++)
      if (k % 8 == 0) tick_q.push_back(k);
  endtask

  task automatic exp_dir(input int at, input logic v);
    dir_exp_t d;
    d.at  = at;
    d.val = v;
    dir_q.push_back(d);
  endtask

  // Monitor: every tick pulse and every count_up edge must match the queue front.
  initial begin
    logic     prev_up;
    int       e;
    dir_exp_t d;
    prev_up = 1'b1;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        prev_up = count_up;
      end else begin
        if (tick === 1'b1) begin
          if (tick_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_unexpected: tick=1 at cyc %0d, none expected", cyc);
          end else begin
            e = tick_q.pop_front();
            check_int("tick_cycle", cyc, e);
            $display("tick at cyc %0d (expected %0d)", cyc, e);
          end
        end
        if (count_up !== prev_up) begin
          if (dir_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dir_unexpected: count_up=%0b at cyc %0d, no change expected", count_up, cyc);
          end else begin
            d = dir_q.pop_front();
            check_int("dir_cycle", cyc, d.at);
            check_bit("dir_value", count_up, d.val);
            $display("count_up -> %0b at cyc %0d (expected %0b at %0d)", count_up, cyc, d.val, d.at);
          end
          prev_up = count_up;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_bit("rst_count_up", count_up, 1'b1);
    check_bit("rst_tick", tick, 1'b0);
    check_bit("rst_paused", paused, 1'b0);
    reset = 1'b0;

    // Idle: ticks at 8, 16, 24
    plan_ticks(1, 30);
    goto(30);
    check_bit("idle_count_up", count_up, 1'b1);
    check_bit("idle_paused", paused, 1'b0);

    // Clean down press: 2 + 4 + 1 + 1 = 8 cycles latency
    plan_ticks(31, 50);
    btn_down = 1'b1;
    exp_dir(38, 1'b0);
    goto(37);
    check_bit("down_not_early", count_up, 1'b1);
    goto(40);
    btn_down = 1'b0;
    goto(50);
    check_bit("down_level", count_up, 1'b0);

    // Bouncing up button (2-cycle toggles), then held
    plan_ticks(51, 90);
    exp_dir(78, 1'b1);
    for (int i = 0; i < 10; i++) begin
      btn_up = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn_up = 1'b1;
    goto(77);
    check_bit("bounce_not_early", count_up, 1'b0);
    goto(80);
    btn_up = 1'b0;
    goto(90);
    check_bit("bounce_level", count_up, 1'b1);

    // Simultaneous presses at 90 and 110 (events land at 97 and 117)
`ifdef DIR_CTRL_PAUSE_EN
    plan_ticks(91, 97);
    plan_ticks(118, 130);
`else
    plan_ticks(91, 130);
`endif
    btn_up = 1'b1;
    btn_down = 1'b1;
    goto(98);
    btn_up = 1'b0;
    btn_down = 1'b0;
    goto(104);
`ifdef DIR_CTRL_PAUSE_EN
    check_bit("both_paused", paused, 1'b1);
    check_bit("both_no_tick", tick, 1'b0);
`else
    check_bit("both_paused", paused, 1'b0);
    check_bit("both_tick", tick, 1'b1);
`endif
    check_bit("both_count_up", count_up, 1'b1);
    goto(110);
    btn_up = 1'b1;
    btn_down = 1'b1;
    goto(118);
    btn_up = 1'b0;
    btn_down = 1'b0;
    goto(130);
    check_bit("both2_paused", paused, 1'b0);
    check_bit("both2_count_up", count_up, 1'b1);

    // Reset in the middle of a down debounce
    plan_ticks(131, 154);
    btn_down = 1'b1;
    exp_dir(138, 1'b0);
    goto(140);
    btn_down = 1'b0;
    goto(150);
    check_bit("pre_rst_down", count_up, 1'b0);
    btn_down = 1'b1;
    goto(154);
    #2 reset = 1'b1;
    #1;
    check_bit("midrst_count_up", count_up, 1'b1);
    check_bit("midrst_tick", tick, 1'b0);
    check_bit("midrst_paused", paused, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    plan_ticks(1, 20);
    exp_dir(8, 1'b0);
    goto(7);
    check_bit("postrst_refilter", count_up, 1'b1);
    goto(12);
    btn_down = 1'b0;
    goto(20);

    // Down press pulse coinciding with the tick at cycle 56
    plan_ticks(21, 90);
    btn_up = 1'b1;
    exp_dir(28, 1'b1);
    goto(30);
    btn_up = 1'b0;
    goto(49);
    btn_down = 1'b1;
    exp_dir(57, 1'b0);
    goto(56);
    check_bit("coinc_tick", tick, 1'b1);
    check_bit("coinc_dir_holds", count_up, 1'b1);
    goto(59);
    btn_down = 1'b0;
    goto(90);
    repeat (4) @(negedge clk);

    check_int("ticks_outstanding", tick_q.size(), 0);
    check_int("dirs_outstanding", dir_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
